axi_ar_mux: RTL and testbench
=============================

Name: axi_ar_mux

Overview:
- Read-path N:1 AXI multiplexer that places several read masters in front of a single read slave port. Covers the AR and R channels only.
- Arbitrates AR round-robin and prepends the granted master index as the high ID bits. Routes R beats back to the originating master by decoding those high bits.
- Sits directly upstream of the ID downsizer. Placing the index in the high bits means the downsizer truncates the index and keeps the original master ID bits.
- AR output is registered (forward slice); the R path is combinational.

Parameters:
- N_MASTERS, 2, number of master ports, at least 2, need not be a power of two.
- ID_WIDTH, 4, master-side ID width.
- IDX_W, $clog2(N_MASTERS), index bits prepended to the ID; derived, not overridden.
- AR_PL_WIDTH, 45, packed AR payload {addr[31:0], len[7:0], size[2:0], burst[1:0]}; carried opaquely.
- R_PL_WIDTH, 67, packed R payload {data[63:0], resp[1:0], last}; bit 0 is last; carried opaquely.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- m_ar_id  in  N_MASTERS x ID_WIDTH  per-master AR ID.
- m_ar_pl  in  N_MASTERS x AR_PL_WIDTH  per-master AR payload.
- m_ar_valid  in  N_MASTERS  per-master AR valid.
- m_ar_ready  out  N_MASTERS  per-master AR ready, one-hot or zero.
- m_r_id  out  ID_WIDTH  R ID, shared by all masters (s_r_id low bits).
- m_r_pl  out  R_PL_WIDTH  R payload, shared by all masters.
- m_r_valid  out  N_MASTERS  per-master R valid.
- m_r_ready  in  N_MASTERS  per-master R ready.
- s_ar_id  out  IDX_W+ID_WIDTH  {grant index, master ID}.
- s_ar_pl  out  AR_PL_WIDTH  registered AR payload.
- s_ar_valid  out  1  registered AR valid.
- s_ar_ready  in  1  slave AR ready.
- s_r_id  in  IDX_W+ID_WIDTH  slave R ID.
- s_r_pl  in  R_PL_WIDTH  slave R payload.
- s_r_valid  in  1  slave R valid.
- s_r_ready  out  1  slave R ready.

Behaviour:
- Reset (rst high at a clock edge):
  - s_ar_valid=0 and rr_ptr=0.
  - m_ar_ready=0 while rst is high.
  - Any AR held in the output register is discarded; no partial handshake survives.
- State:
  - One-entry output register {s_ar_id, s_ar_pl, s_ar_valid}.
  - Round-robin pointer rr_ptr, range 0..N_MASTERS-1.
- Accept condition: accept = !s_ar_valid || s_ar_ready.
- Grant:
  - When accept=1, g is the first index with m_ar_valid set, searching rr_ptr, rr_ptr+1, ... and wrapping modulo N_MASTERS.
  - m_ar_ready[g]=1; all other bits 0. If no master is valid, m_ar_ready=0.
  - m_ar_ready depends combinationally on m_ar_valid and s_ar_ready; it never depends on the master's own ready.
- On grant at edge k:
  - s_ar_id <= {g[IDX_W-1:0], m_ar_id[g]}, s_ar_pl <= m_ar_pl[g], s_ar_valid <= 1.
  - rr_ptr <= (g==N_MASTERS-1) ? 0 : g+1. The wrap is explicit and correct for non-power-of-two N.
  - s_ar_valid is visible from cycle k+1, giving exactly 1 cycle of latency.
- On accept with no grant: s_ar_valid <= 0 if the register was being drained; rr_ptr is unchanged.
- Stall: while s_ar_valid && !s_ar_ready, s_ar_id and s_ar_pl hold stable and no master sees ready.
- Throughput: back-to-back, 1 AR per cycle while s_ar_ready stays high.
- R routing:
  - idx = s_r_id[IDX_W+ID_WIDTH-1:ID_WIDTH].
  - m_r_valid[i] = s_r_valid && idx==i.
  - s_r_ready = m_r_ready[idx].
  - m_r_id and m_r_pl are broadcast unchanged.
- Out-of-range idx (idx >= N_MASTERS): no m_r_valid bit is set and s_r_ready=1, so the beat is sunk and dropped. This case is only reachable with non-power-of-two N.
- No R-side state: burst interleaving between different IDs passes through unchanged, and the last bit is not interpreted.
- Simultaneous events: an AR grant and R traffic in the same cycle are independent; no cross-channel stall.

Test Plan:
- Reset, then m_ar_valid=2'b11 with s_ar_ready=1 held.
  - Grants in order m0, m1, m0, m1.
  - s_ar_id[4]=0,1,0,1 starting 1 cycle after the first m_ar_ready.
  - One AR per cycle.
- m0 valid with id=4'hA, pl=X; s_ar_ready=0 for 3 cycles.
  - s_ar_valid=1 and s_ar_id=5'h0A stable for all 3 cycles.
  - m_ar_ready=0 throughout.
  - Accepted on the 4th cycle.
- N_MASTERS=3, all three valid continuously.
  - Grant sequence 0,1,2,0,1,2; rr_ptr wraps from 2 to 0.
  - s_ar_id[5:4]=0,1,2,0,...
- s_r_id=5'h13, s_r_valid=1, m_r_ready=2'b01.
  - m_r_valid=2'b10 and m_r_id=4'h3.
  - s_r_ready=0 until m_r_ready[1] rises.
- N_MASTERS=3, s_r_id={2'd3, 4'h0}, s_r_valid=1.
  - m_r_valid=0 and s_r_ready=1; the beat is dropped.
- AR held in the register, s_ar_ready=0, rst pulsed for 1 cycle.
  - s_ar_valid=0 the following cycle; rr_ptr=0.
  - The next grant goes to the lowest valid index.

Source files
------------

// File: rtl/axi_ar_mux.sv
// N:1 AXI read-path multiplexer: round-robin AR arbitration with a registered
// forward slice, grant index prepended as high ID bits, combinational R routing.
module axi_ar_mux #(
  parameter  int unsigned N_MASTERS   = 2,
  parameter  int unsigned ID_WIDTH    = 4,
  parameter  int unsigned AR_PL_WIDTH = 45,
  parameter  int unsigned R_PL_WIDTH  = 67,
  localparam int unsigned IDX_W       = $clog2(N_MASTERS),
  localparam int unsigned SID_W       = IDX_W + ID_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_MASTERS-1:0][ID_WIDTH-1:0]    m_ar_id,
  input  logic [N_MASTERS-1:0][AR_PL_WIDTH-1:0] m_ar_pl,
  input  logic [N_MASTERS-1:0]                  m_ar_valid,
  output logic [N_MASTERS-1:0]                  m_ar_ready,
  output logic [ID_WIDTH-1:0]                   m_r_id,
  output logic [R_PL_WIDTH-1:0]                 m_r_pl,
  output logic [N_MASTERS-1:0]                  m_r_valid,
  input  logic [N_MASTERS-1:0]                  m_r_ready,
  output logic [SID_W-1:0]                      s_ar_id,
  output logic [AR_PL_WIDTH-1:0]                s_ar_pl,
  output logic                                  s_ar_valid,
  input  logic                                  s_ar_ready,
  input  logic [SID_W-1:0]                      s_r_id,
  input  logic [R_PL_WIDTH-1:0]                 s_r_pl,
  input  logic                                  s_r_valid,
  output logic                                  s_r_ready
);

  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SID_W-1:0]       ar_id_q, ar_id_d;
  logic [AR_PL_WIDTH-1:0] ar_pl_q, ar_pl_d;
  logic                   ar_valid_q, ar_valid_d;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_found;
  logic                   accept;
  logic [IDX_W-1:0]       r_idx;

  // Modulo-N step from the pointer without relying on power-of-two wrap.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                 input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= N_MASTERS) sum = sum - N_MASTERS;
    return IDX_W'(sum);
  endfunction

  assign accept = !ar_valid_q || s_ar_ready;

  // Round-robin search starting at the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned off = 0; off < N_MASTERS; off++) begin
      if (!grant_found && m_ar_valid[wrap_idx(rr_ptr_q, off)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(rr_ptr_q, off);
      end
    end
  end

  always_comb begin
    m_ar_ready = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      m_ar_ready[i] = !rst && accept && grant_found && (grant_idx == IDX_W'(i));
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    ar_id_d    = ar_id_q;
    ar_pl_d    = ar_pl_q;
    ar_valid_d = ar_valid_q;
    if (accept) begin
      ar_valid_d = grant_found;
      if (grant_found) begin
        ar_id_d  = {grant_idx, m_ar_id[grant_idx]};
        ar_pl_d  = m_ar_pl[grant_idx];
        rr_ptr_d = (grant_idx == IDX_W'(N_MASTERS - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      ar_id_q    <= '0;
      ar_pl_q    <= '0;
      ar_valid_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      ar_id_q    <= ar_id_d;
      ar_pl_q    <= ar_pl_d;
      ar_valid_q <= ar_valid_d;
    end
  end

  assign s_ar_id    = ar_id_q;
  assign s_ar_pl    = ar_pl_q;
  assign s_ar_valid = ar_valid_q;

  // R routing; an index with no matching master leaves ready high so the beat is sunk.
  assign r_idx  = s_r_id[SID_W-1:ID_WIDTH];
  assign m_r_id = s_r_id[ID_WIDTH-1:0];
  assign m_r_pl = s_r_pl;

  always_comb begin
    m_r_valid = '0;
    s_r_ready = 1'b1;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        m_r_valid[i] = s_r_valid;
        s_r_ready    = m_r_ready[i];
      end
    end
  end

endmodule

// File: tb/tb_axi_ar_mux.sv
// Self-checking bench for axi_ar_mux: a 2-master and a 3-master instance checked
// every cycle against a behavioural model, plus directed scenario checks.
module tb_axi_ar_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-master instance signals
  logic [1:0][3:0]  id2;
  logic [1:0][44:0] pl2;
  logic [1:0]       v2, rdy2, mrv2, mrdy2;
  logic [3:0]       mrid2;
  logic [66:0]      mpl2, rpl2;
  logic [4:0]       sid2, rsid2;
  logic [44:0]      spl2;
  logic             sv2, sr2, rsv2, srr2;

  // 3-master instance signals
  logic [2:0][3:0]  id3;
  logic [2:0][44:0] pl3;
  logic [2:0]       v3, rdy3, mrv3, mrdy3;
  logic [3:0]       mrid3;
  logic [66:0]      mpl3, rpl3;
  logic [5:0]       sid3, rsid3;
  logic [44:0]      spl3;
  logic             sv3, sr3, rsv3, srr3;

  axi_ar_mux #(.N_MASTERS(2)) dut2 (
    .clk(clk), .rst(rst),
    .m_ar_id(id2), .m_ar_pl(pl2), .m_ar_valid(v2), .m_ar_ready(rdy2),
    .m_r_id(mrid2), .m_r_pl(mpl2), .m_r_valid(mrv2), .m_r_ready(mrdy2),
    .s_ar_id(sid2), .s_ar_pl(spl2), .s_ar_valid(sv2), .s_ar_ready(sr2),
    .s_r_id(rsid2), .s_r_pl(rpl2), .s_r_valid(rsv2), .s_r_ready(srr2)
  );

  axi_ar_mux #(.N_MASTERS(3)) dut3 (
    .clk(clk), .rst(rst),
    .m_ar_id(id3), .m_ar_pl(pl3), .m_ar_valid(v3), .m_ar_ready(rdy3),
    .m_r_id(mrid3), .m_r_pl(mpl3), .m_r_valid(mrv3), .m_r_ready(mrdy3),
    .s_ar_id(sid3), .s_ar_pl(spl3), .s_ar_valid(sv3), .s_ar_ready(sr3),
    .s_r_id(rsid3), .s_r_pl(rpl3), .s_r_valid(rsv3), .s_r_ready(srr3)
  );

  int tests = 0;
  int fails = 0;

  // Reference state per instance (0: two masters, 1: three masters).
  int          mrp[2];
  bit          mv[2];
  int          mid[2];
  logic [44:0] mpl[2];
  int          lastg[2];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // AR side: checks this cycle's outputs, then advances the model across the edge.
  task automatic model_ar(input int d, input int n, input int valid, input bit sready,
                          input bit r, input logic [2:0][3:0] ids,
                          input logic [2:0][44:0] pls, input int got_rdy,
                          input bit got_sv, input int got_sid, input logic [44:0] got_spl);
    int g, j;
    bit acc;
    chk($sformatf("d%0d s_ar_valid", d), got_sv, mv[d]);
    if (mv[d]) begin
      chk($sformatf("d%0d s_ar_id", d), got_sid, mid[d]);
      chk($sformatf("d%0d s_ar_pl", d), got_spl, mpl[d]);
    end
    acc = !mv[d] || sready;
    g = -1;
    if (acc && !r) begin
      for (int k = 0; k < n; k++) begin
        j = (mrp[d] + k) % n;
        if (g < 0 && valid[j]) g = j;
      end
    end
    chk($sformatf("d%0d m_ar_ready", d), got_rdy, (g >= 0) ? (1 << g) : 0);
    lastg[d] = g;
    if (r) begin
      mv[d] = 1'b0;
      mrp[d] = 0;
    end else if (acc) begin
      if (g >= 0) begin
        mv[d]  = 1'b1;
        mid[d] = g * 16 + int'(ids[g]);
        mpl[d] = pls[g];
        mrp[d] = (g + 1) % n;
      end else begin
        mv[d] = 1'b0;
      end
    end
  endtask

  // R side: pure routing function of the current inputs.
  task automatic model_r(input int d, input int n, input int sid, input logic [66:0] spl,
                         input bit sv, input int mrdy, input int got_mrv, input bit got_srdy,
                         input int got_mrid, input logic [66:0] got_mpl);
    int idx;
    idx = sid / 16;
    chk($sformatf("d%0d m_r_valid", d), got_mrv, (sv && idx < n) ? (1 << idx) : 0);
    chk($sformatf("d%0d s_r_ready", d), got_srdy, (idx < n) ? mrdy[idx] : 1);
    chk($sformatf("d%0d m_r_id", d), got_mrid, sid % 16);
    chk($sformatf("d%0d m_r_pl", d), got_mpl, spl);
  endtask

  task automatic check_all();
    model_r(0, 2, int'(rsid2), rpl2, rsv2, int'(mrdy2), int'(mrv2), srr2, int'(mrid2), mpl2);
    model_ar(0, 2, int'(v2), sr2, rst, {4'h0, id2}, {45'h0, pl2}, int'(rdy2), sv2,
             int'(sid2), spl2);
    model_r(1, 3, int'(rsid3), rpl3, rsv3, int'(mrdy3), int'(mrv3), srr3, int'(mrid3), mpl3);
    model_ar(1, 3, int'(v3), sr3, rst, id3, pl3, int'(rdy3), sv3, int'(sid3), spl3);
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    check_all();
    advance();
  endtask

  initial begin
    rst = 1'b1;
    id2 = '0; pl2 = '0; v2 = '0; sr2 = 1'b0; rsid2 = '0; rpl2 = '0; rsv2 = 1'b0; mrdy2 = '0;
    id3 = '0; pl3 = '0; v3 = '0; sr3 = 1'b0; rsid3 = '0; rpl3 = '0; rsv3 = 1'b0; mrdy3 = '0;
    for (int d = 0; d < 2; d++) begin
      mrp[d] = 0; mv[d] = 1'b0; mid[d] = 0; mpl[d] = '0; lastg[d] = -1;
    end
    advance();
    // Reset held: outputs idle, ready suppressed even with requests pending.
    v2 = 2'b11; v3 = 3'b111;
    cycle();
    v2 = '0; v3 = '0;
    rst = 1'b0;

    // Two masters contending with slave always ready: alternating grants, one per cycle.
    for (int i = 0; i < 2; i++) begin
      id2[i] = 4'($urandom);
      pl2[i] = 45'({$urandom(), $urandom()});
    end
    v2 = 2'b11; sr2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) v2 = 2'b00;
      settle();
      check_all();
      if (k < 4) chk("rr2 grant", lastg[0], k % 2);
      if (k > 0) begin
        chk("rr2 s_ar_valid", sv2, 1);
        chk("rr2 s_ar_id idx", sid2[4], (k - 1) % 2);
      end
      advance();
    end

    // Slave stall: registered AR held stable, no master ready until the slave accepts.
    id2[0] = 4'hA;
    pl2[0] = 45'({$urandom(), $urandom()});
    v2 = 2'b01; sr2 = 1'b1;
    cycle();
    sr2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_all();
      chk("stall s_ar_valid", sv2, 1);
      chk("stall s_ar_id", sid2, 5'h0A);
      chk("stall s_ar_pl", spl2, pl2[0]);
      chk("stall m_ar_ready", rdy2, 2'b00);
      advance();
    end
    sr2 = 1'b1;
    settle();
    check_all();
    chk("stall release m_ar_ready", rdy2, 2'b01);
    advance();
    v2 = 2'b00;
    cycle();

    // Three masters, non-power-of-two wrap of the pointer.
    for (int i = 0; i < 3; i++) begin
      id3[i] = 4'($urandom);
      pl3[i] = 45'({$urandom(), $urandom()});
    end
    v3 = 3'b111; sr3 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) v3 = 3'b000;
      settle();
      check_all();
      if (k < 6) chk("rr3 grant", lastg[1], k % 3);
      if (k > 0) chk("rr3 s_ar_id idx", sid3[5:4], (k - 1) % 3);
      advance();
    end
    cycle();

    // R routing by high ID bits; backpressure follows the addressed master.
    rsid2 = 5'h13; rpl2 = 67'({$urandom(), $urandom(), $urandom()}); rsv2 = 1'b1;
    mrdy2 = 2'b01;
    settle();
    check_all();
    chk("r2 m_r_valid", mrv2, 2'b10);
    chk("r2 m_r_id", mrid2, 4'h3);
    chk("r2 s_r_ready low", srr2, 1'b0);
    advance();
    mrdy2 = 2'b11;
    settle();
    check_all();
    chk("r2 s_r_ready high", srr2, 1'b1);
    advance();
    rsv2 = 1'b0;

    // Out-of-range index with three masters is sunk.
    rsid3 = {2'd3, 4'h0}; rpl3 = 67'({$urandom(), $urandom(), $urandom()}); rsv3 = 1'b1;
    mrdy3 = 3'b000;
    settle();
    check_all();
    chk("r3 oor m_r_valid", mrv3, 3'b000);
    chk("r3 oor s_r_ready", srr3, 1'b1);
    advance();
    rsv3 = 1'b0;

    // Reset while an AR is stalled in the register: it is discarded and the pointer clears.
    v2 = 2'b01; sr2 = 1'b1;
    cycle();
    sr2 = 1'b0;
    cycle();
    rst = 1'b1;
    settle();
    check_all();
    chk("rst m_ar_ready", rdy2, 2'b00);
    advance();
    rst = 1'b0;
    v2 = 2'b11; sr2 = 1'b1;
    settle();
    check_all();
    chk("post-rst s_ar_valid", sv2, 1'b0);
    chk("post-rst m_ar_ready", rdy2, 2'b01);
    advance();
    v2 = 2'b00;
    cycle();

    // Random traffic on both instances, with occasional resets.
    for (int it = 0; it < 400; it++) begin
      rst = ($urandom_range(0, 39) == 0);
      v2 = 2'($urandom); sr2 = ($urandom_range(0, 3) != 0);
      v3 = 3'($urandom); sr3 = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        id2[i] = 4'($urandom);
        pl2[i] = 45'({$urandom(), $urandom()});
      end
      for (int i = 0; i < 3; i++) begin
        id3[i] = 4'($urandom);
        pl3[i] = 45'({$urandom(), $urandom()});
      end
      rsid2 = 5'($urandom); rpl2 = 67'({$urandom(), $urandom(), $urandom()});
      rsv2 = 1'($urandom); mrdy2 = 2'($urandom);
      rsid3 = 6'($urandom); rpl3 = 67'({$urandom(), $urandom(), $urandom()});
      rsv3 = 1'($urandom); mrdy3 = 3'($urandom);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
